// File: rtl/dh_input_conditioner.sv
// Multi-channel pad input conditioner: synchroniser, optional inversion, debounce or bypass,
// registered rise/fall pulses and a long-hold flag per channel.
module dh_input_conditioner #(
  parameter int              N_CH            = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 650000,
  parameter int              HOLD_CYCLES     = 0,
  parameter logic [N_CH-1:0] INVERT_MASK     = '0,
  parameter logic [N_CH-1:0] BYPASS_MASK     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic {IDLE, PENDING} state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg, state_next;
      logic [CW-1:0]          cnt_reg, cnt_next;
      logic                   level_reg, level_next;
      logic                   rise_reg, fall_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_raw[gi]};
        end
      end

      // Inversion after the chain, so active-low channels read active until pad data arrives.
      assign s = sync_reg[SYNC_STAGES-1] ^ INVERT_MASK[gi];

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        if (BYPASS_MASK[gi]) begin
          level_next = s;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (s != level_reg) begin
                if (DEBOUNCE_CYCLES == 1) begin
                  level_next = s;
                end else begin
                  state_next = PENDING;
                  cnt_next   = CW'(1);
                end
              end
            end
            PENDING: begin
              if (s == level_reg) begin
                state_next = IDLE;
                cnt_next   = '0;
              end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_next = s;
                state_next = IDLE;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_reg + CW'(1);
              end
            end
            default: begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
          rise_reg  <= level_next & ~level_reg;
          fall_reg  <= ~level_next & level_reg;
        end
      end

      assign level[gi] = level_reg;
      assign rise[gi]  = rise_reg;
      assign fall[gi]  = fall_reg;

      if (HOLD_CYCLES > 0) begin : g_hold
        logic [HW-1:0] hold_reg, hold_next;
        logic          held_reg;

        always_comb begin
          hold_next = '0;
          if (level_reg) begin
            hold_next = (hold_reg == HW'(HOLD_CYCLES)) ? hold_reg : hold_reg + HW'(1);
          end
        end

        // Gated with level_next so held falls on the same edge as level.
        always_ff @(posedge clk) begin
          if (rst) begin
            hold_reg <= '0;
            held_reg <= 1'b0;
          end else begin
            hold_reg <= hold_next;
            held_reg <= level_next & (hold_next == HW'(HOLD_CYCLES));
          end
        end

        assign held[gi] = held_reg;
      end else begin : g_nohold
        assign held[gi] = 1'b0;
      end
    end
  endgenerate

endmodule
